// File: rtl/output_bridge_arbiter.sv
// Round-robin arbiter sharing one FPGA-to-HPS output bridge among NREQ requesters.
// Define OUTPUT_BRIDGE_TIMEOUT_EN to abort transactions that wait too long for acknowledge.
module output_bridge_arbiter #(
  parameter int NREQ           = 4,
  parameter int IDW            = $clog2(NREQ),
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_write,
  input  logic [30*NREQ-1:0] req_address,
  input  logic [8*NREQ-1:0] req_byte_enable,
  input  logic [64*NREQ-1:0] req_write_data,
  output logic [NREQ-1:0]   req_ack,
  output logic              req_err,
  output logic [63:0]       req_read_data,
  output logic [29:0]       ei_address,
  output logic [7:0]        ei_byte_enable,
  output logic              ei_read,
  output logic              ei_write,
  output logic [63:0]       ei_write_data,
  input  logic              ei_acknowledge,
  input  logic [63:0]       ei_read_data,
  output logic              busy,
  output logic [IDW-1:0]    grant_id,
  output logic              timeout_flag,
  output logic [7:0]        err_count
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   last_grant_reg;
  logic [IDW-1:0]   grant_id_reg;
  logic [29:0]      addr_reg;
  logic [7:0]       be_reg;
  logic [63:0]      wdata_reg;
  logic             ei_read_reg;
  logic             ei_write_reg;
  logic [NREQ-1:0]  req_ack_reg;
  logic [63:0]      req_read_data_reg;
  logic             busy_reg;

  logic [29:0]      addr_arr  [NREQ];
  logic [7:0]       be_arr    [NREQ];
  logic [63:0]      wdata_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_address[gi*30 +: 30];
      assign be_arr[gi]    = req_byte_enable[gi*8 +: 8];
      assign wdata_arr[gi] = req_write_data[gi*64 +: 64];
    end
  endgenerate

  // Search starts just after the last grantee and wraps, so every requester is reached.
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand_idx;
  logic           pick_found;
  int             cand;

  always_comb begin
    pick_idx   = '0;
    pick_found = 1'b0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand     = (int'(last_grant_reg) + k) % NREQ;
      cand_idx = IDW'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
  localparam int CNTW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT_CYCLES - 1);

  logic [CNTW-1:0] wait_cnt_reg;
  logic            req_err_reg;
  logic            timeout_flag_reg;
  logic [7:0]      err_count_reg;
`endif

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_reg         <= IDLE;
      last_grant_reg    <= IDW'(NREQ - 1);
      grant_id_reg      <= '0;
      addr_reg          <= '0;
      be_reg            <= '0;
      wdata_reg         <= '0;
      ei_read_reg       <= 1'b0;
      ei_write_reg      <= 1'b0;
      req_ack_reg       <= '0;
      req_read_data_reg <= '0;
      busy_reg          <= 1'b0;
`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
      wait_cnt_reg      <= '0;
      req_err_reg       <= 1'b0;
      timeout_flag_reg  <= 1'b0;
      err_count_reg     <= '0;
`endif
    end else begin
      req_ack_reg <= '0;
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_id_reg <= pick_idx;
            addr_reg     <= addr_arr[pick_idx];
            be_reg       <= be_arr[pick_idx];
            wdata_reg    <= wdata_arr[pick_idx];
            ei_read_reg  <= !req_write[pick_idx];
            ei_write_reg <= req_write[pick_idx];
            busy_reg     <= 1'b1;
            state_reg    <= BUSY;
`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end
        BUSY: begin
          // Acknowledge wins over a timeout reached in the same cycle.
          if (ei_acknowledge) begin
            ei_read_reg                <= 1'b0;
            ei_write_reg               <= 1'b0;
            req_ack_reg[grant_id_reg]  <= 1'b1;
            req_read_data_reg          <= ei_write_reg ? 64'd0 : ei_read_data;
            state_reg                  <= ACK;
          end
`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
          else if (wait_cnt_reg == CNT_LAST) begin
            ei_read_reg               <= 1'b0;
            ei_write_reg              <= 1'b0;
            req_ack_reg[grant_id_reg] <= 1'b1;
            req_read_data_reg         <= '0;
            req_err_reg               <= 1'b1;
            timeout_flag_reg          <= 1'b1;
            if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
            state_reg                 <= ACK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
`endif
        end
        ACK: begin
          last_grant_reg <= grant_id_reg;
          busy_reg       <= 1'b0;
          state_reg      <= IDLE;
`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
          req_err_reg    <= 1'b0;
`endif
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ei_address     = addr_reg;
  assign ei_byte_enable = be_reg;
  assign ei_write_data  = wdata_reg;
  assign ei_read        = ei_read_reg;
  assign ei_write       = ei_write_reg;
  assign req_ack        = req_ack_reg;
  assign req_read_data  = req_read_data_reg;
  assign busy           = busy_reg;
  assign grant_id       = grant_id_reg;

`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
  assign req_err      = req_err_reg;
  assign timeout_flag = timeout_flag_reg;
  assign err_count    = err_count_reg;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign req_err        = 1'b0;
  assign timeout_flag   = 1'b0;
  assign err_count      = 8'd0;
`endif

endmodule

// File: tb/tb_output_bridge_arbiter.sv
// Randomized and directed bench for output_bridge_arbiter with a transaction-level
// round-robin model and a bridge responder; timeout cases run when OUTPUT_BRIDGE_TIMEOUT_EN is set.
module tb_output_bridge_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TO   = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset_reset_n;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_write;
  logic [30*NREQ-1:0]   req_address;
  logic [8*NREQ-1:0]    req_byte_enable;
  logic [64*NREQ-1:0]   req_write_data;
  logic [NREQ-1:0]      req_ack;
  logic                 req_err;
  logic [63:0]          req_read_data;
  logic [29:0]          ei_address;
  logic [7:0]           ei_byte_enable;
  logic                 ei_read;
  logic                 ei_write;
  logic [63:0]          ei_write_data;
  logic                 ei_acknowledge;
  logic [63:0]          ei_read_data;
  logic                 busy;
  logic [IDW-1:0]       grant_id;
  logic                 timeout_flag;
  logic [7:0]           err_count;

  logic [29:0] r_addr  [NREQ];
  logic [7:0]  r_be    [NREQ];
  logic [63:0] r_wdata [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_pack
      assign req_address[gi*30 +: 30]   = r_addr[gi];
      assign req_byte_enable[gi*8 +: 8] = r_be[gi];
      assign req_write_data[gi*64 +: 64] = r_wdata[gi];
    end
  endgenerate

  output_bridge_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
    .clk_clk(clk), .reset_reset_n(reset_reset_n),
    .req_valid(req_valid), .req_write(req_write), .req_address(req_address),
    .req_byte_enable(req_byte_enable), .req_write_data(req_write_data),
    .req_ack(req_ack), .req_err(req_err), .req_read_data(req_read_data),
    .ei_address(ei_address), .ei_byte_enable(ei_byte_enable), .ei_read(ei_read),
    .ei_write(ei_write), .ei_write_data(ei_write_data), .ei_acknowledge(ei_acknowledge),
    .ei_read_data(ei_read_data), .busy(busy), .grant_id(grant_id),
    .timeout_flag(timeout_flag), .err_count(err_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic int rr_pick(input int last, input logic [NREQ-1:0] v);
    logic [IDW-1:0] jj;
    for (int k = 1; k <= NREQ; k++) begin
      jj = IDW'((last + k) % NREQ);
      if (v[jj]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  // Reference state: who was granted last, bridge behaviour, expected completion.
  int              cyc = 0;
  logic [NREQ-1:0] sampled_valid = '0;
  int              model_last = NREQ - 1;
  int              ack_delay = 1;
  int              cur_delay = 0;
  int              bcount = 0;
  int              w = 0;
  int              n_txn = 0;
  logic [IDW-1:0]  wi = '0;
  logic [NREQ-1:0] exp_ack;
  bit              prev_strobe = 0;
  bit              strobe;
  bit              acked = 0;
  bit              rand_delay = 0;
  bit              fixed_en = 0;
  logic [63:0]     fixed_rdata = '0;
  logic [63:0]     exp_data = '0;

  always @(posedge clk) begin
    cyc++;
    sampled_valid = req_valid;
  end

  always @(negedge clk) begin
    if (!reset_reset_n) begin
      prev_strobe    = 0;
      model_last     = NREQ - 1;
      bcount         = 0;
      acked          = 0;
      ei_acknowledge = 1'b0;
      ei_read_data   = '0;
    end else begin
      strobe = ei_read | ei_write;
      if (strobe && !prev_strobe) begin
        w = rr_pick(model_last, sampled_valid);
        cur_delay = rand_delay ? int'($urandom_range(1, 6)) : ack_delay;
        bcount = 0;
        acked  = 0;
        check_eq("grant_has_requester", 64'(w >= 0), 1);
        if (w < 0) w = 0;
        wi = IDW'(w);
        check_eq("grant_id", grant_id, wi);
        check_eq("direction", ei_write, req_write[wi]);
      end
      if (strobe) begin
        bcount++;
        check_eq("strobe_exclusive", ei_read & ei_write, 0);
        check_eq("busy_in_txn", busy, 1);
        check_eq("bus_address", ei_address, r_addr[wi]);
        check_eq("bus_byte_enable", ei_byte_enable, r_be[wi]);
        check_eq("bus_write_data", ei_write_data, r_wdata[wi]);
        check_eq("no_ack_while_busy", req_ack, 0);
        ei_acknowledge = (cur_delay != 0) && (bcount == cur_delay);
        if (ei_acknowledge) begin
          acked        = 1;
          ei_read_data = fixed_en ? fixed_rdata : {$urandom, $urandom};
          exp_data     = ei_write ? 64'd0 : ei_read_data;
        end
      end else begin
        ei_acknowledge = 1'b0;
        if (prev_strobe) begin
          exp_ack = '0;
          exp_ack[wi] = 1'b1;
          check_eq("req_ack", req_ack, exp_ack);
`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
          check_eq("req_err", req_err, !acked);
          check_eq("read_data", req_read_data, acked ? exp_data : 64'd0);
          check_eq("strobe_len", bcount, acked ? cur_delay : TO);
`else
          check_eq("acked", acked, 1);
          check_eq("req_err", req_err, 0);
          check_eq("read_data", req_read_data, exp_data);
          check_eq("strobe_len", bcount, cur_delay);
`endif
          $display("txn %0d: req %0d %s addr 0x%0h len %0d err %0d rdata 0x%0h",
                   n_txn, w, req_write[wi] ? "wr" : "rd", r_addr[wi], bcount, req_err, req_read_data);
          model_last = w;
          n_txn++;
        end else begin
          check_eq("idle_no_ack", req_ack, 0);
        end
      end
      prev_strobe = strobe;
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  task automatic wait_ack(input int budget, output int idx, output int at_cyc);
    idx = -1;
    at_cyc = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (req_ack != '0) begin
        for (int i = 0; i < NREQ; i++) if (req_ack[i]) idx = i;
        at_cyc = cyc;
        break;
      end
    end
    check_eq("ack_within_budget", 64'(idx >= 0), 1);
    #2;
  endtask

  task automatic wait_strobe(input int budget);
    bit seen;
    seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (ei_read | ei_write) begin
        seen = 1;
        break;
      end
    end
    check_eq("strobe_within_budget", 64'(seen), 1);
    #2;
  endtask

  task automatic rand_fields(input int i);
    r_addr[i]    = 30'($urandom);
    r_be[i]      = 8'($urandom);
    r_wdata[i]   = {$urandom, $urandom};
    req_write[i] = 1'($urandom);
  endtask

  int idx, at_c, prev_c;

  initial begin
    reset_reset_n = 1'b0;
    req_valid = '0;
    req_write = '0;
    for (int i = 0; i < NREQ; i++) begin
      r_addr[i] = '0; r_be[i] = '0; r_wdata[i] = '0;
    end
    idle_cycles(3);

    check_eq("rst_req_ack", req_ack, 0);
    check_eq("rst_ei_read", ei_read, 0);
    check_eq("rst_ei_write", ei_write, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_grant_id", grant_id, 0);
    check_eq("rst_read_data", req_read_data, 0);
    check_eq("rst_address", ei_address, 0);
    check_eq("rst_err", req_err, 0);
    check_eq("rst_timeout_flag", timeout_flag, 0);
    check_eq("rst_err_count", err_count, 0);

    // All requesters valid from reset, immediate acknowledge.
    for (int i = 0; i < NREQ; i++) rand_fields(i);
    req_valid = '1;
    ack_delay = 1;
    reset_reset_n = 1'b1;
    prev_c = 0;
    for (int k = 0; k < 2 * NREQ; k++) begin
      wait_ack(20, idx, at_c);
      check_eq("rr_order", idx, k % NREQ);
      if (k > 0) check_eq("rr_spacing", at_c - prev_c, 3);
      prev_c = at_c;
    end
    req_valid = '0;
    idle_cycles(3);

    // Single read from requester 2, acknowledged after 5 cycles.
    r_addr[2] = 30'h0000100; r_be[2] = 8'hFF; req_write[2] = 1'b0;
    fixed_en = 1; fixed_rdata = 64'hDEADBEEF_01234567;
    ack_delay = 5;
    req_valid[2] = 1'b1;
    wait_ack(20, idx, at_c);
    check_eq("read_ack_vec", req_ack, 4'b0100);
    check_eq("read_data_ret", req_read_data, 64'hDEADBEEF_01234567);
    check_eq("read_err", req_err, 0);
    req_valid = '0;
    fixed_en = 0;
    idle_cycles(2);

    // Write from requester 1.
    r_addr[1] = 30'h2ABCDEF; r_be[1] = 8'h0F; r_wdata[1] = 64'h11223344_55667788;
    req_write[1] = 1'b1;
    ack_delay = 3;
    req_valid[1] = 1'b1;
    wait_strobe(10);
    check_eq("wr_ei_write", ei_write, 1);
    check_eq("wr_ei_read", ei_read, 0);
    check_eq("wr_address", ei_address, 30'h2ABCDEF);
    check_eq("wr_byte_enable", ei_byte_enable, 8'h0F);
    check_eq("wr_data", ei_write_data, 64'h11223344_55667788);
    wait_ack(20, idx, at_c);
    check_eq("wr_ack_vec", req_ack, 4'b0010);
    check_eq("wr_read_data_zero", req_read_data, 0);
    req_valid = '0;
    idle_cycles(2);

    // Reset asserted in the middle of a BUSY cycle.
    rand_fields(3);
    req_write[3] = 1'b0;
    ack_delay = 0;
    req_valid[3] = 1'b1;
    wait_strobe(10);
    @(negedge clk);
    #3;
    reset_reset_n = 1'b0;
    #1;
    check_eq("rst_mid_ei_read", ei_read, 0);
    check_eq("rst_mid_ei_write", ei_write, 0);
    check_eq("rst_mid_busy", busy, 0);
    repeat (2) begin
      @(negedge clk);
      check_eq("rst_mid_no_ack", req_ack, 0);
    end
    #2;
    req_valid = '1;
    ack_delay = 1;
    reset_reset_n = 1'b1;
    wait_ack(10, idx, at_c);
    check_eq("post_reset_grant", idx, 0);
    req_valid = '0;
    idle_cycles(2);

`ifdef OUTPUT_BRIDGE_TIMEOUT_EN
    req_write[0] = 1'b0;
    ack_delay = 0;
    req_valid[0] = 1'b1;
    wait_ack(40, idx, at_c);
    check_eq("to_ack_idx", idx, 0);
    check_eq("to_err", req_err, 1);
    check_eq("to_read_data", req_read_data, 0);
    check_eq("to_flag", timeout_flag, 1);
    check_eq("to_count", err_count, 1);
    req_valid = '0;
    idle_cycles(2);
    ack_delay = TO;
    req_valid[0] = 1'b1;
    wait_ack(40, idx, at_c);
    check_eq("edge_ack_err", req_err, 0);
    check_eq("edge_ack_count", err_count, 1);
    req_valid = '0;
    idle_cycles(2);
`else
    check_eq("no_to_flag", timeout_flag, 0);
    check_eq("no_to_count", err_count, 0);
`endif

    // Randomized requesters and bridge latencies.
    rand_delay = 1;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      #2;
      for (int i = 0; i < NREQ; i++) begin
        if (req_ack[i]) begin
          if ($urandom_range(0, 1) == 1) rand_fields(i);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          rand_fields(i);
          req_valid[i] = 1'b1;
        end
      end
    end
    req_valid = '0;
    idle_cycles(15);
    check_eq("drained_idle", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/output_bridge_arbiter.md
# output_bridge_arbiter

Round-robin arbiter that shares the single FPGA-to-HPS output bridge (30-bit word address, 64-bit data, 8-bit byte enable, read/write strobes, acknowledge) among NREQ fabric requesters such as per-channel radar result writers. Each requester presents one transaction at a time. The arbiter latches and issues it on the bridge, waits for `ei_acknowledge`, and returns a one-cycle completion with read data. It sits between the radar processing pipeline and the `system_output_bridge_ei_*` ports of the HPS subsystem.

## Interface
Parameters:
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default $clog2(NREQ): width of the grant index.
- `TIMEOUT_CYCLES`, default 1024: maximum cycles spent waiting for acknowledge; used only with the timeout feature.

Ports:
- `clk_clk` in 1: the single clock.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: request pending, one bit per requester.
- `req_write` in NREQ: per requester, 1 = write, 0 = read.
- `req_address` in 30*NREQ: packed word addresses; requester i uses bits [30i+29:30i].
- `req_byte_enable` in 8*NREQ: packed byte enables.
- `req_write_data` in 64*NREQ: packed write data.
- `req_ack` out NREQ: one-cycle completion pulse to the granted requester.
- `req_err` out 1: valid together with `req_ack`; 1 = aborted by timeout.
- `req_read_data` out 64: valid together with `req_ack`.
- `ei_address` out 30: to `system_output_bridge_ei_address`.
- `ei_byte_enable` out 8: to the bridge.
- `ei_read` out 1: to the bridge.
- `ei_write` out 1: to the bridge.
- `ei_write_data` out 64: to the bridge.
- `ei_acknowledge` in 1: from the bridge.
- `ei_read_data` in 64: from the bridge.
- `busy` out 1: state is not IDLE.
- `grant_id` out IDW: index of the current or last grantee.
- `timeout_flag` out 1: sticky; set on any timeout.
- `err_count` out 8: saturating count of timeouts.

## Operation
- States: IDLE, BUSY, ACK.
- IDLE, any `req_valid` set:
  - Select the winner by round robin. Search starts at `last_grant+1` and wraps modulo NREQ.
  - Latch the winner's address, byte enable, write data and direction into registers; set `grant_id`.
  - Go to BUSY.
- BUSY:
  - `ei_read` or `ei_write` (per the latched direction) is high, with address, byte enable and data held stable.
  - On `ei_acknowledge`=1: capture `ei_read_data` for reads (0 for writes), drop the strobes, go to ACK.
- ACK:
  - `req_ack[grant_id]`=1 for exactly one cycle; `last_grant` <= `grant_id`.
  - Return to IDLE. `req_valid` is not sampled in ACK.
- Requester rules:
  - Hold `req_valid` and the request fields until `req_ack`.
  - Deassert `req_valid` in the cycle after `req_ack`, or keep it high to request again.
  - Deasserting `req_valid` during BUSY does not cancel the transaction.
- Reset values: all outputs 0, state IDLE. `last_grant` = NREQ-1, so requester 0 has highest priority after reset.
- Reset asserted mid-transaction: strobes drop immediately (asynchronously) and no `req_ack` is issued.
- `ei_read` and `ei_write` are never high together. Both are low outside BUSY.

## Timing
- `req_valid` high in IDLE cycle N -> bus strobe high from cycle N+1.
- `ei_acknowledge` high in cycle M -> strobe low and `req_ack` high in cycle M+1 -> IDLE in cycle M+2.
- Minimum transaction is 3 cycles (acknowledge in the first BUSY cycle). Back-to-back grants are spaced by at least 3 cycles.
- All outputs are registered; there is no combinational path from `ei_*` inputs to `req_*` outputs.

## Configuration
- `OUTPUT_BRIDGE_TIMEOUT_EN` defined:
  - A BUSY cycle counter runs. If TIMEOUT_CYCLES BUSY cycles elapse without acknowledge, the strobes drop and the transaction moves to ACK.
  - In that ACK cycle, `req_err`=1 and `req_read_data`=0.
  - `timeout_flag` is set; `err_count` increments, saturating at 255.
  - Acknowledge in the same cycle the limit is reached counts as success.
- `OUTPUT_BRIDGE_TIMEOUT_EN` undefined:
  - BUSY waits indefinitely for acknowledge.
  - `req_err`, `timeout_flag` and `err_count` are tied to 0, and no counter is synthesized.

## Test plan
- Single read: req 2 reads address 0x0000100, bridge acks after 5 cycles with data 0xDEADBEEF_01234567.
  - Required: `ei_read` high for exactly 5 cycles, `req_ack`=4'b0100 for 1 cycle with that data, `req_err`=0.
- All four requesters valid continuously from reset, immediate acks.
  - Required: grant order 0,1,2,3,0,…, with `req_ack` pulses every 3 cycles.
- Write with byte enable 8'h0F and data 0x11223344_55667788 from req 1.
  - Required: bus fields match exactly, `ei_write` only, returned `req_read_data`=0.
- `reset_reset_n` pulsed low mid-BUSY.
  - Required: strobes low within the same cycle, no `req_ack`, next grant goes to requester 0.
- With the macro and TIMEOUT_CYCLES=16, no acknowledge.
  - Required: strobe high for 16 cycles, then `req_ack` with `req_err`=1, `timeout_flag`=1, `err_count`=1.
- Acknowledge on exactly cycle 16 with TIMEOUT_CYCLES=16.
  - Required: success, `req_err`=0, `err_count` unchanged.
